// File: rtl/rtc_bus_scheduler_pkg.sv
// Shared types and constants for the RTC bus scheduler: FSM states, sweep table, bus drive helper.
// Latency: n/a (package, no logic of its own).
// Backpressure: n/a.
package rtc_bus_pkg;

    localparam int NUM_REGS = 9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_A_SET = 3'd1,
        S_A_STB = 3'd2,
        S_A_HLD = 3'd3,
        S_D_SET = 3'd4,
        S_D_STB = 3'd5,
        S_D_HLD = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // Registers read back by the refresh sweep, in display order:
    // seg, min, hora, dia, mes, anno, tseg, tmin, thora (entry 0 in the low byte).
    localparam logic [NUM_REGS-1:0][7:0] SWEEP_ADDR = {
        8'h43, 8'h42, 8'h41, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
    };

    // Everything the scheduler drives onto the external bus, registered as one word.
    typedef struct packed {
        logic       cs_n;
        logic       ad_sel;
        logic       wr_n;
        logic       rd_n;
        logic       ad_oe;
        logic [7:0] ad_out;
    } bus_drv_t;

    localparam bus_drv_t BUS_IDLE = '{
        cs_n: 1'b1, ad_sel: 1'b1, wr_n: 1'b1, rd_n: 1'b1, ad_oe: 1'b0, ad_out: 8'h00
    };

    function automatic logic [7:0] sweep_addr(input logic [3:0] idx);
        return (idx < 4'(NUM_REGS)) ? SWEEP_ADDR[idx] : 8'h00;
    endfunction

    // Successor of a timed phase state; DONE follows the data hold phase.
    function automatic state_t next_phase(input state_t s);
        case (s)
            S_A_SET: return S_A_STB;
            S_A_STB: return S_A_HLD;
            S_A_HLD: return S_D_SET;
            S_D_SET: return S_D_STB;
            S_D_STB: return S_D_HLD;
            S_D_HLD: return S_DONE;
            default: return S_IDLE;
        endcase
    endfunction

    // Bus pin values to present while in state s. The address is always latched
    // by the chip with wr_n; the data phase uses wr_n or rd_n depending on direction.
    function automatic bus_drv_t bus_drive(input state_t s, input logic is_wr,
                                           input logic [7:0] addr, input logic [7:0] data);
        bus_drv_t d;
        d = BUS_IDLE;
        case (s)
            S_A_SET, S_A_STB, S_A_HLD: begin
                d.cs_n   = 1'b0;
                d.ad_sel = 1'b0;
                d.ad_oe  = 1'b1;
                d.ad_out = addr;
                d.wr_n   = (s != S_A_STB);
            end
            S_D_SET, S_D_STB, S_D_HLD: begin
                d.cs_n   = 1'b0;
                d.ad_sel = 1'b1;
                d.ad_oe  = is_wr;
                d.ad_out = is_wr ? data : 8'h00;
                if (is_wr) d.wr_n = (s != S_D_STB);
                else       d.rd_n = (s != S_D_STB);
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rtc_bus_scheduler_if.sv
// User-request, read-back and external RTC bus signals of the scheduler, bundled.
// Latency: n/a (wiring only).
// Backpressure: wr_req is a level held until wr_ack; reads are unsolicited pulses.
interface rtc_bus_scheduler_if;
    logic       refresh_en;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       rd_valid;
    logic [3:0] rd_idx;
    logic [7:0] rd_data;
    logic       busy;
    logic       cs_n;
    logic       ad_sel;
    logic       wr_n;
    logic       rd_n;
    logic       ad_oe;
    logic [7:0] ad_out;
    logic [7:0] ad_in;

    modport master (
        input  refresh_en, wr_req, wr_addr, wr_data, ad_in,
        output wr_ack, rd_valid, rd_idx, rd_data, busy,
               cs_n, ad_sel, wr_n, rd_n, ad_oe, ad_out
    );

    modport slave (
        output refresh_en, wr_req, wr_addr, wr_data, ad_in,
        input  wr_ack, rd_valid, rd_idx, rd_data, busy,
               cs_n, ad_sel, wr_n, rd_n, ad_oe, ad_out
    );
endinterface

// File: rtl/rtc_bus_scheduler_refresh_timer.sv
// Free-running refresh period counter; tick marks the last count before wrap.
// Latency: tick is high for one clock every REFRESH_CYCLES clocks.
// Backpressure: none; ticks are never held, the consumer drops what it cannot take.
module rtc_refresh_timer #(
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..REFRESH_CYCLES-1 and wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                cnt <= '0;
        else if (cnt == CNT_LAST) cnt <= '0;
        else                      cnt <= cnt + CNT_W'(1);
    end

    assign tick = (cnt == CNT_LAST);
endmodule

// File: rtl/rtc_bus_scheduler.sv
// Sequences every access to the external RTC bus: user writes win over a periodic 9-register read sweep.
// Latency: 6*PHASE_CYCLES+1 clocks per transaction plus 1 idle clock; ack/valid in the final clock.
// Backpressure: wr_req is held until wr_ack; sweep ticks arriving while a sweep is pending are dropped.
module rtc_bus_scheduler
    import rtc_bus_pkg::*;
#(
    parameter int PHASE_CYCLES   = 4,
    parameter int REFRESH_CYCLES = 100000
) (
    input logic               clk,
    input logic               reset,
    rtc_bus_scheduler_if.master bus
);
    localparam int PH_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PHASE_CYCLES - 1);
    localparam logic [3:0]      IDX_LAST = 4'(NUM_REGS - 1);

    state_t          state;
    logic [PH_W-1:0] ph_cnt;
    logic            is_wr;
    logic [7:0]      cur_addr;
    logic [7:0]      cur_data;
    bus_drv_t        drv;
    logic            wr_ack_q;
    logic            rd_valid_q;
    logic            busy_q;
    logic [3:0]      rd_idx_q;
    logic [7:0]      rd_data_q;
    logic [3:0]      sweep_idx;
    logic            sweep_pend;
    logic            tick;

    rtc_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Transaction FSM: arbitration in IDLE, timed phases, sweep bookkeeping and
    // bus drive all advance together so every output is a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            ph_cnt     <= '0;
            is_wr      <= 1'b0;
            cur_addr   <= '0;
            cur_data   <= '0;
            drv        <= BUS_IDLE;
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            rd_idx_q   <= '0;
            rd_data_q  <= '0;
            sweep_idx  <= '0;
            sweep_pend <= 1'b0;
        end else begin
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    ph_cnt <= '0;
                    if (bus.wr_req) begin
                        is_wr    <= 1'b1;
                        cur_addr <= bus.wr_addr;
                        cur_data <= bus.wr_data;
                        state    <= S_A_SET;
                        busy_q   <= 1'b1;
                        drv      <= bus_drive(S_A_SET, 1'b1, bus.wr_addr, bus.wr_data);
                    end else if (sweep_pend && bus.refresh_en) begin
                        is_wr    <= 1'b0;
                        cur_addr <= sweep_addr(sweep_idx);
                        cur_data <= 8'h00;
                        state    <= S_A_SET;
                        busy_q   <= 1'b1;
                        drv      <= bus_drive(S_A_SET, 1'b0, sweep_addr(sweep_idx), 8'h00);
                    end else if (sweep_pend) begin
                        // Refresh disabled with a sweep outstanding: abandon it.
                        sweep_pend <= 1'b0;
                        sweep_idx  <= '0;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    drv    <= BUS_IDLE;
                    if (!is_wr) begin
                        if (sweep_idx == IDX_LAST) begin
                            sweep_pend <= 1'b0;
                            sweep_idx  <= '0;
                        end else begin
                            sweep_idx <= sweep_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    // Sample the chip's answer while rd_n is still low.
                    if (state == S_D_STB && !is_wr && ph_cnt == PH_LAST)
                        rd_data_q <= bus.ad_in;
                    if (ph_cnt == PH_LAST) begin
                        ph_cnt <= '0;
                        state  <= next_phase(state);
                        drv    <= bus_drive(next_phase(state), is_wr, cur_addr, cur_data);
                        if (state == S_D_HLD) begin
                            if (is_wr) begin
                                wr_ack_q <= 1'b1;
                            end else begin
                                rd_valid_q <= 1'b1;
                                rd_idx_q   <= sweep_idx;
                            end
                        end
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
            endcase
            // A new sweep only starts from a clean slate; ticks during a pending sweep are lost.
            if (tick && !sweep_pend) begin
                sweep_pend <= 1'b1;
                sweep_idx  <= '0;
            end
        end
    end

    assign bus.wr_ack   = wr_ack_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_idx   = rd_idx_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = busy_q;
    assign bus.cs_n     = drv.cs_n;
    assign bus.ad_sel   = drv.ad_sel;
    assign bus.wr_n     = drv.wr_n;
    assign bus.rd_n     = drv.rd_n;
    assign bus.ad_oe    = drv.ad_oe;
    assign bus.ad_out   = drv.ad_out;
endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Bench for rtc_bus_scheduler: RTC register-file model on the bus plus a response scoreboard.
// Latency: each transaction is 13 clocks with PHASE_CYCLES=2; done pulses chain 14 edges apart.
// Backpressure: stimulus holds wr_req until wr_ack, as a user FSM would.
`timescale 1ns/1ps
module tb_rtc_bus_scheduler;
    localparam int PH  = 2;
    localparam int REF = 200;
    localparam int GAP = 6 * PH + 2;   // edges between successive done pulses (13 clocks between them)

    typedef struct {
        bit wr;
        int idx;
        int addr;
        int data;
        int gap;   // 0 = spacing not checked
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rtc_bus_scheduler_if bus();

    rtc_bus_scheduler #(
        .PHASE_CYCLES   (PH),
        .REFRESH_CYCLES (REF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RTC chip model state
    logic [7:0] mem [256];
    logic [7:0] alat;
    logic [7:0] sw_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [7:0] pre_dat [9] = '{8'h59, 8'h34, 8'h12, 8'h28, 8'h02, 8'h24, 8'h05, 8'h10, 8'h01};
    assign bus.ad_in = mem[alat];

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // monitor bookkeeping
    int cyc = 0, last_done = 0, cs_run = 0, cs_len = 0;
    int n_astb = 0, n_dwstb = 0, n_drstb = 0, proto_bad = 0;
    logic [7:0] wdat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input bit wr, input int idx, input int addr, input int data, input int gap);
        exp_t e;
        e.wr = wr; e.idx = idx; e.addr = addr; e.data = data; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_sweep(input int from, input int to, input int first_gap);
        for (int i = from; i <= to; i++)
            push(1'b0, i, sw_addr[i], pre_dat[i], (i == from) ? first_gap : GAP);
    endtask

    // Chip model and scoreboard monitor, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                for (int i = 0; i < 256; i++) mem[i] = 8'h00;
                for (int i = 0; i < 9; i++) mem[sw_addr[i]] = pre_dat[i];
                alat   = 8'h00;
                cs_run = 0;
            end else begin
                if (!bus.cs_n) begin
                    if (cs_run == 0) begin
                        n_astb = 0; n_dwstb = 0; n_drstb = 0; proto_bad = 0;
                    end
                    cs_run++;
                    if (!bus.wr_n && !bus.rd_n) proto_bad = 1;
                    if (!bus.wr_n) begin
                        if (!bus.ad_oe) proto_bad = 1;
                        if (!bus.ad_sel) begin
                            alat = bus.ad_out;
                            n_astb++;
                        end else begin
                            mem[alat] = bus.ad_out;
                            wdat = bus.ad_out;
                            n_dwstb++;
                        end
                    end
                    if (!bus.rd_n) begin
                        if (bus.ad_oe || !bus.ad_sel) proto_bad = 1;
                        n_drstb++;
                    end
                end else if (cs_run != 0) begin
                    cs_len = cs_run;
                    cs_run = 0;
                end

                if (bus.wr_ack || bus.rd_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_wr_ack", bus.wr_ack, 0);
                        check("unexpected_rd_valid", bus.rd_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("kind_wr_ack", bus.wr_ack, e.wr);
                        check("kind_rd_valid", bus.rd_valid, !e.wr);
                        check("cs_low_clocks", cs_len, 6 * PH);
                        check("addr_strobe_clocks", n_astb, PH);
                        check("bus_addr", alat, e.addr);
                        check("strobe_protocol", proto_bad, 0);
                        if (e.gap != 0) check("done_spacing", cyc - last_done, e.gap);
                        if (e.wr) begin
                            check("wr_data_strobe_clocks", n_dwstb, PH);
                            check("wr_rd_strobe_clocks", n_drstb, 0);
                            check("wr_bus_data", wdat, e.data);
                            check("model_reg", mem[e.addr[7:0]], e.data);
                        end else begin
                            check("rd_strobe_clocks", n_drstb, PH);
                            check("rd_wr_data_strobes", n_dwstb, 0);
                            check("rd_idx", bus.rd_idx, e.idx);
                            check("rd_data", bus.rd_data, e.data);
                        end
                    end
                    last_done = cyc;
                end
            end
        end
    end

    task automatic wait_negedges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.wr_req = 1'b0;
        wait_negedges(3);
        reset = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget && lat == 0; i++) begin
            @(negedge clk);
            if (bus.wr_ack) lat = i;
        end
        if (lat == 0) check("wr_ack_timeout", lat, 1);
    endtask

    task automatic wait_rd(input int n, input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            @(negedge clk);
            if (bus.rd_valid) seen++;
        end
        if (seen < n) check("rd_valid_timeout", seen, n);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int found;
        int acks;
        bus.refresh_en = 1'b0;
        bus.wr_req     = 1'b0;
        bus.wr_addr    = 8'h00;
        bus.wr_data    = 8'h00;

        // reset values
        wait_negedges(3);
        check("rst_cs_n", bus.cs_n, 1);
        check("rst_wr_n", bus.wr_n, 1);
        check("rst_rd_n", bus.rd_n, 1);
        check("rst_ad_sel", bus.ad_sel, 1);
        check("rst_ad_oe", bus.ad_oe, 0);
        check("rst_ad_out", bus.ad_out, 0);
        check("rst_wr_ack", bus.wr_ack, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rd_idx", bus.rd_idx, 0);
        check("rst_rd_data", bus.rd_data, 0);
        reset = 1'b0;

        // 1: single write from idle
        wait_negedges(5);
        push(1'b1, 0, 'h22, 'h45, 0);
        bus.wr_addr = 8'h22;
        bus.wr_data = 8'h45;
        bus.wr_req  = 1'b1;
        wait_ack(60, lat);
        bus.wr_req = 1'b0;
        check("wr_ack_latency", lat, 13);
        wait_drain(20);

        // 2: full refresh sweep
        do_reset();
        bus.refresh_en = 1'b1;
        push_sweep(0, 8, 0);
        wait_drain(700);
        wait_negedges(2);
        check("busy_after_sweep", bus.busy, 0);
        bus.refresh_en = 1'b0;

        // 3: write collides with sweep item 3; it lands on anno, read back as item 5
        do_reset();
        bus.refresh_en = 1'b1;
        push_sweep(0, 3, 0);
        push(1'b1, 0, 'h26, 'h99, GAP);
        push(1'b0, 4, sw_addr[4], pre_dat[4], GAP);
        push(1'b0, 5, 'h26, 'h99, GAP);
        push_sweep(6, 8, GAP);
        wait_rd(3, 400);
        wait_negedges(4);
        bus.wr_addr = 8'h26;
        bus.wr_data = 8'h99;
        bus.wr_req  = 1'b1;
        wait_ack(80, lat);
        bus.wr_req = 1'b0;
        wait_drain(400);
        bus.refresh_en = 1'b0;

        // 4: refresh disabled during item 2, next sweep restarts at index 0
        do_reset();
        bus.refresh_en = 1'b1;
        push_sweep(0, 2, 0);
        push_sweep(0, 8, 0);
        wait_rd(2, 400);
        wait_negedges(4);
        bus.refresh_en = 1'b0;
        wait_rd(1, 60);
        wait_negedges(5);
        bus.refresh_en = 1'b1;
        wait_drain(600);
        bus.refresh_en = 1'b0;

        // 5: async reset in the data strobe of a write
        do_reset();
        bus.wr_addr = 8'h50;
        bus.wr_data = 8'h11;
        bus.wr_req  = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (!bus.wr_n && bus.ad_sel) found = 1;
        end
        check("reach_data_strobe", found, 1);
        reset = 1'b1;
        bus.wr_req = 1'b0;
        #1;
        check("abort_cs_n", bus.cs_n, 1);
        check("abort_wr_n", bus.wr_n, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_wr_ack", bus.wr_ack, 0);
        wait_negedges(2);
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.wr_ack) acks++;
        end
        check("abort_no_ack", acks, 0);

        // 6: wr_req held through two acks; pending sweep waits for it to drop
        do_reset();
        bus.refresh_en = 1'b1;
        push(1'b1, 0, 'h30, 'h11, 0);
        push(1'b1, 0, 'h31, 'h22, GAP);
        push_sweep(0, 8, GAP);
        wait_negedges(188);
        bus.wr_addr = 8'h30;
        bus.wr_data = 8'h11;
        bus.wr_req  = 1'b1;
        wait_ack(60, lat);
        bus.wr_addr = 8'h31;
        bus.wr_data = 8'h22;
        wait_ack(60, lat);
        check("b2b_ack_spacing", lat, GAP);
        bus.wr_req = 1'b0;
        wait_drain(400);
        bus.refresh_en = 1'b0;

        wait_negedges(5);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
